// File: rtl/hamming_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package : hamming_pkg
// Shared Hamming(12,8) constants, codeword index lists and rx FSM states.
// Revision: 1.0
// ============================================================================
package hamming_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  // Element [k] is the codeword index of parity bit p(2^k).
  localparam logic [SYN_W-1:0][3:0] PARITY_IDX = {4'd7, 4'd3, 4'd1, 4'd0};

  // Element [j] is the codeword index of data bit dj.
  localparam logic [DATA_W-1:0][3:0] DATA_IDX =
    {4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2};

  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/hamming_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Interface : hamming_serial_rx_if
// Serial codeword input and decoded-byte output handshake of the receiver.
// Revision: 1.0
// ============================================================================
interface hamming_serial_rx_if #(
  parameter int CNT_W = 16
) ();
  import hamming_pkg::*;

  logic              ser_valid;
  logic              ser_data;
  logic              ser_sof;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              err_corr;
  logic              err_uncorr;
  logic              overrun;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;

  modport master (
    output ser_valid, ser_data, ser_sof, out_ready,
    input  data_out, out_valid, err_corr, err_uncorr, overrun,
           corr_count, uncorr_count
  );

  modport slave (
    input  ser_valid, ser_data, ser_sof, out_ready,
    output data_out, out_valid, err_corr, err_uncorr, overrun,
           corr_count, uncorr_count
  );

endinterface
`default_nettype wire

// File: rtl/hamming_serial_rx_correct.sv
`default_nettype none
// ============================================================================
// Module : hamming_correct
// Combinational syndrome, single-bit correction and data extraction.
// Revision: 1.0
// ============================================================================
module hamming_correct
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_corr_o,
  output logic              err_uncorr_o
);

  logic [SYN_W-1:0] syn;
  logic [CW_W-1:0]  fixed;
  logic [4:0]       pos;

  always_comb begin
    syn = '0;
    pos = '0;
    // Received parity XOR parity recomputed over the data bits it covers.
    for (int k = 0; k < SYN_W; k++) begin
      syn[k] = cw_i[PARITY_IDX[k]];
      for (int j = 0; j < DATA_W; j++) begin
        pos    = {1'b0, DATA_IDX[j]} + 5'd1;
        syn[k] = syn[k] ^ (pos[k] & cw_i[DATA_IDX[j]]);
      end
    end

    err_corr_o   = (syn != '0) && (syn <= 4'(CW_W));
    err_uncorr_o = (syn > 4'(CW_W));

    fixed = cw_i;
    for (int i = 0; i < CW_W; i++) begin
      if (err_corr_o && (syn == 4'(i + 1))) begin
        fixed[i] = ~cw_i[i];
      end
    end

    data_o = '0;
    for (int j = 0; j < DATA_W; j++) begin
      data_o[j] = fixed[DATA_IDX[j]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hamming_serial_rx.sv
`default_nettype none
// ============================================================================
// Module : hamming_serial_rx
// Serial Hamming(12,8) receiver: deserialise, correct, hold one output word.
// Error counters exist only when HAMMING_SERIAL_RX_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hamming_serial_rx_if.slave  bus
);

  rx_state_e         state_q;
  logic [3:0]        bit_cnt_q;
  logic [CW_W-2:0]   shift_q;
  logic [CW_W-1:0]   dec_q;
  logic              dec_valid_q;

  logic [DATA_W-1:0] res_data_q;
  logic              res_corr_q;
  logic              res_uncorr_q;
  logic              res_valid_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              corr_q;
  logic              uncorr_q;
  logic              overrun_q;

  logic [DATA_W-1:0] fix_data;
  logic              fix_corr;
  logic              fix_uncorr;
  logic              xfer;
  logic              load;

  // Deserialiser; a qualified sof restarts the frame from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      dec_valid_q <= 1'b0;
      if (bus.ser_valid) begin
        if (bus.ser_sof) begin
          shift_q   <= {{(CW_W-2){1'b0}}, bus.ser_data};
          bit_cnt_q <= 4'd1;
          state_q   <= RX_SHIFT;
        end else if (state_q == RX_SHIFT) begin
          if (bit_cnt_q == 4'(CW_W - 1)) begin
            dec_q       <= {bus.ser_data, shift_q};
            dec_valid_q <= 1'b1;
            bit_cnt_q   <= '0;
            state_q     <= RX_IDLE;
          end else begin
            shift_q[bit_cnt_q] <= bus.ser_data;
            bit_cnt_q          <= bit_cnt_q + 4'd1;
          end
        end
      end
    end
  end

  hamming_correct u_correct (
    .cw_i         (dec_q),
    .data_o       (fix_data),
    .err_corr_o   (fix_corr),
    .err_uncorr_o (fix_uncorr)
  );

  assign xfer = out_valid_q & bus.out_ready;
  assign load = res_valid_q & (~out_valid_q | bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data_q   <= '0;
      res_corr_q   <= 1'b0;
      res_uncorr_q <= 1'b0;
      res_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      res_valid_q <= dec_valid_q;
      if (dec_valid_q) begin
        res_data_q   <= fix_data;
        res_corr_q   <= fix_corr;
        res_uncorr_q <= fix_uncorr;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        data_q      <= res_data_q;
        corr_q      <= res_corr_q;
        uncorr_q    <= res_uncorr_q;
      end else begin
        if (xfer) begin
          out_valid_q <= 1'b0;
        end
        if (res_valid_q) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

`ifdef HAMMING_SERIAL_RX_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (load) begin
      if (res_corr_q && (corr_cnt_q != '1)) begin
        corr_cnt_q <= corr_cnt_q + CNT_W'(1);
      end
      if (res_uncorr_q && (uncorr_cnt_q != '1)) begin
        uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.corr_count   = corr_cnt_q;
  assign bus.uncorr_count = uncorr_cnt_q;
`else
  assign bus.corr_count   = {CNT_W{1'b0}};
  assign bus.uncorr_count = {CNT_W{1'b0}};
`endif

  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_q;
  assign bus.err_corr   = corr_q;
  assign bus.err_uncorr = uncorr_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_serial_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_hamming_serial_rx
// Directed and randomised bench for hamming_serial_rx with a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_hamming_serial_rx;

  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAMMING_SERIAL_RX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int DIDX [8] = '{2, 4, 5, 6, 8, 9, 10, 11};

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       u;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_serial_rx_if #(.CNT_W(CNT_W)) bus ();

  hamming_serial_rx #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_tests   = 0;
  int    n_fail    = 0;
  bit    chk_en    = 1'b0;
  int    dut_xfers = 0;

  // Model state
  int          cyc    = 0;
  bit          m_valid;
  word_t       m_w;
  bit          m_ovr;
  int          m_cc, m_uc;
  int          nbits;
  logic [11:0] acc;
  word_t       pipe_w[$];
  int          pipe_due[$];

  function automatic logic [11:0] cov_mask(input int k);
    logic [11:0] m = '0;
    for (int p = 1; p <= 12; p++) if (((p >> k) & 1) == 1) m[p-1] = 1'b1;
    return m;
  endfunction

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] cw = '0;
    for (int j = 0; j < 8; j++) cw[DIDX[j]] = d[j];
    for (int k = 0; k < 4; k++) cw[(1 << k) - 1] = ^(cw & cov_mask(k));
    return cw;
  endfunction

  function automatic word_t decode_ref(input logic [11:0] cw);
    word_t       r;
    int          syn = 0;
    logic [11:0] fixed = cw;
    for (int k = 0; k < 4; k++) if (^(cw & cov_mask(k))) syn += (1 << k);
    r.c = 1'b0;
    r.u = 1'b0;
    if (syn >= 1 && syn <= 12) begin
      fixed[syn-1] = ~fixed[syn-1];
      r.c = 1'b1;
    end else if (syn >= 13) begin
      r.u = 1'b1;
    end
    for (int j = 0; j < 8; j++) r.d[j] = fixed[DIDX[j]];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    word_t w;
    cyc++;
    if (!rst_n) begin
      m_valid = 1'b0; m_w = '0; m_ovr = 1'b0; m_cc = 0; m_uc = 0;
      nbits = 0; acc = '0;
      pipe_w.delete(); pipe_due.delete();
    end else begin
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
        w = pipe_w.pop_front();
        void'(pipe_due.pop_front());
        if (m_valid) m_ovr = 1'b1;
        else begin
          m_valid = 1'b1;
          m_w     = w;
          if (CNT_ON) begin
            if (w.c && m_cc < CMAX) m_cc++;
            if (w.u && m_uc < CMAX) m_uc++;
          end
        end
      end
      if (bus.ser_valid) begin
        if (bus.ser_sof) begin
          acc = '0; acc[0] = bus.ser_data; nbits = 1;
        end else if (nbits > 0) begin
          acc[nbits] = bus.ser_data;
          nbits++;
          if (nbits == 12) begin
            pipe_w.push_back(decode_ref(acc));
            pipe_due.push_back(cyc + 2);
            nbits = 0;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) dut_xfers++;
    if (chk_en) begin
      check("out_valid",    32'(bus.out_valid),    32'(m_valid));
      check("data_out",     32'(bus.data_out),     32'(m_w.d));
      check("err_corr",     32'(bus.err_corr),     32'(m_w.c));
      check("err_uncorr",   32'(bus.err_uncorr),   32'(m_w.u));
      check("overrun",      32'(bus.overrun),      32'(m_ovr));
      check("corr_count",   32'(bus.corr_count),   32'(m_cc));
      check("uncorr_count", 32'(bus.uncorr_count), 32'(m_uc));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 expected end");
    $fatal(1, "watchdog");
  end

  function automatic bit rr();
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic step(input bit v, input bit d, input bit s, input bit rdy);
    bus.ser_valid = v;
    bus.ser_data  = d;
    bus.ser_sof   = s;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [11:0] cw, input bit rnd, input bit rdy);
    for (int i = 0; i < 12; i++) begin
      if (rnd && $urandom_range(0, 3) == 0)
        step(1'b0, 1'($urandom), 1'($urandom), rr());
      step(1'b1, cw[i], (i == 0), rnd ? rr() : rdy);
    end
  endtask

  task automatic wait_out(input bit rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  logic [11:0] cw;
  logic [7:0]  dv;
  int          nf, nb, xbase;
  bit          ok;

  initial begin
    bus.ser_valid = 1'b0; bus.ser_data = 1'b0; bus.ser_sof = 1'b0; bus.out_ready = 1'b0;

    check("pin_encode_a5",  32'(encode(8'hA5)),      32'h0A27);
    check("pin_dec_clean",  32'(decode_ref(12'hA27)), {22'd0, 8'hA5, 2'b00});
    check("pin_dec_corr",   32'(decode_ref(12'hA07)), {22'd0, 8'hA5, 2'b10});
    check("pin_dec_uncorr", 32'(decode_ref(12'h226)), {22'd0, 8'h25, 2'b01});

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data_out",  32'(bus.data_out),  32'd0);
    check("rst_overrun",   32'(bus.overrun),   32'd0);
    rst_n = 1'b1;

    // Clean word and output latency
    send_word(12'hA27, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    check("clean_data",      32'(bus.data_out),  32'hA5);
    check("clean_corr",      32'(bus.err_corr),  32'd0);
    check("clean_uncorr",    32'(bus.err_uncorr), 32'd0);

    // Single-bit error at index 5
    send_word(12'hA07, 1'b0, 1'b1);
    wait_out(1'b1, ok);
    check("corr_seen",  32'(ok),             32'd1);
    check("corr_data",  32'(bus.data_out),   32'hA5);
    check("corr_flag",  32'(bus.err_corr),   32'd1);
    check("corr_count", 32'(bus.corr_count), CNT_ON ? 32'd1 : 32'd0);

    // Double error with syndrome 13
    send_word(12'h226, 1'b0, 1'b1);
    wait_out(1'b1, ok);
    check("uncorr_seen",  32'(ok),               32'd1);
    check("uncorr_data",  32'(bus.data_out),     32'h25);
    check("uncorr_flag",  32'(bus.err_uncorr),   32'd1);
    check("uncorr_count", 32'(bus.uncorr_count), CNT_ON ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: second word dropped
    send_word(12'hA27, 1'b0, 1'b0);
    send_word(12'hA07, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_held_valid", 32'(bus.out_valid),  32'd1);
    check("ovr_held_data",  32'(bus.data_out),   32'hA5);
    check("ovr_held_corr",  32'(bus.err_corr),   32'd0);
    check("ovr_flag",       32'(bus.overrun),    32'd1);
    check("ovr_corr_count", 32'(bus.corr_count), CNT_ON ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Partial frame aborted by sof
    xbase = dut_xfers;
    cw = 12'hA27;
    for (int i = 0; i < 6; i++) step(1'b1, cw[i], (i == 0), 1'b1);
    send_word(12'hA27, 1'b0, 1'b1);
    wait_out(1'b1, ok);
    check("abort_seen", 32'(ok),           32'd1);
    check("abort_data", 32'(bus.data_out), 32'hA5);
    repeat (15) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_one_output", 32'(dut_xfers - xbase), 32'd1);

    // Reset while a word is held
    send_word(12'hA07, 1'b0, 1'b0);
    wait_out(1'b0, ok);
    check("rst2_pre_valid", 32'(ok), 32'd1);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("rst2_out_valid",    32'(bus.out_valid),    32'd0);
    check("rst2_data_out",     32'(bus.data_out),     32'd0);
    check("rst2_err_corr",     32'(bus.err_corr),     32'd0);
    check("rst2_err_uncorr",   32'(bus.err_uncorr),   32'd0);
    check("rst2_overrun",      32'(bus.overrun),      32'd0);
    check("rst2_corr_count",   32'(bus.corr_count),   32'd0);
    check("rst2_uncorr_count", 32'(bus.uncorr_count), 32'd0);

    // Randomised traffic
    for (int f = 0; f < 150; f++) begin
      dv = 8'($urandom);
      cw = encode(dv);
      nf = $urandom_range(0, 2);
      for (int k = 0; k < nf; k++) cw[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 4) == 0) step(1'b1, 1'($urandom), 1'b0, rr());
      if ($urandom_range(0, 5) == 0) begin
        nb = $urandom_range(1, 11);
        for (int k = 0; k < nb; k++) step(1'b1, 1'($urandom), (k == 0), rr());
      end
      if (f == 75) begin
        for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), (k == 0), rr());
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b1, rr());
        rst_n = 1'b1;
      end
      send_word(cw, 1'b1, 1'b0);
    end
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_serial_rx.md
HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

Interface
REQ-001 Parameter: CNT_W, default 16, width of the corrected/uncorrectable error counters.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: ser_valid  input  1  the serial bit on ser_data is valid this cycle.
REQ-005 Port: ser_data  input  1  serial codeword bit, codeword index 0 sent first.
REQ-006 Port: ser_sof  input  1  qualified by ser_valid; marks the current bit as codeword index 0.
REQ-007 Port: data_out  output  8  decoded byte.
REQ-008 Port: out_valid  output  1  data_out and the flags are valid.
REQ-009 Port: out_ready  input  1  sink accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-010 Port: err_corr  output  1  the held byte had a single-bit error that was corrected.
REQ-011 Port: err_uncorr  output  1  the held byte had a syndrome of 13..15 and was not corrected.
REQ-012 Port: overrun  output  1  sticky; a decoded word was dropped because the output was full.
REQ-013 Port: corr_count  output  CNT_W  saturating count of corrected words.
REQ-014 Port: uncorr_count  output  CNT_W  saturating count of uncorrectable words.

Function
REQ-015 Codeword layout: 12 bits; parity at indices 0, 1, 3, 7; d0..d7 at indices 2, 4, 5, 6, 8, 9, 10, 11.
REQ-016 Syndrome: s = {s8, s4, s2, s1}; sK is the XOR of all bits whose position (index+1) has bit K set.
REQ-017 Correction rules by syndrome value:
- s = 0: no flip; err_corr = 0, err_uncorr = 0.
- s = 1..12: invert bit at index s-1; err_corr = 1.
- s = 13..15: no flip; err_uncorr = 1; data_out = the raw data bits.
REQ-018 FSM states:
- IDLE: waits for ser_valid && ser_sof, which loads bit 0 and sets bit_cnt = 1; moves to SHIFT.
- SHIFT: each ser_valid bit is stored at index bit_cnt; when bit_cnt = 11 is received, the codeword is latched into the decode register and the FSM returns to IDLE.
REQ-019 ser_valid low in SHIFT SHALL hold all state, with no timeout.
REQ-020 ser_sof in SHIFT SHALL discard the partial word and restart at index 0 with the current bit.
REQ-021 Latency: index-11 bit accepted at edge N -> decode at edge N+1 -> out_valid high after edge N+2.
REQ-022 The output holds one word: data_out and the flags SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 Decoded word ready while the output register is empty, or is transferring in the same cycle: the output register SHALL load it.
REQ-024 Decoded word ready while the output is full and not transferring: the word is dropped, overrun is set, and the counters are unchanged.
REQ-025 Counters SHALL increment when a word is loaded into the output register and SHALL saturate at all-ones.
REQ-026 The next codeword's bits MAY arrive back-to-back while the previous word is in decode or output.

Reset
REQ-027 With rst_n low at an edge, the following SHALL take these values:
- FSM: IDLE; bit_cnt: 0; shift register: 0; decode-valid: 0.
- out_valid: 0; data_out: 0x00; err_corr: 0; err_uncorr: 0.
- overrun: 0; corr_count: 0; uncorr_count: 0.
REQ-028 Reset mid-frame or mid-handshake SHALL discard all partial and held words.

Configuration
REQ-029 Macro HAMMING_SERIAL_RX_CNT_EN:
- Defined: corr_count and uncorr_count behave per REQ-025.
- Undefined: no counter registers exist and both ports are tied to 0.
- err_corr, err_uncorr and overrun are unaffected in both cases.

Structure
REQ-030 Shared package hamming_pkg SHALL hold:
- Constants CW_W = 12 and DATA_W = 8.
- The parity index list {0, 1, 3, 7} and the data index list.
- The rx FSM state enum.
REQ-031 The combinational syndrome/correct/extract logic SHALL be one sub-module, hamming_correct (12-bit in; 8-bit data, err_corr, err_uncorr out), reusable by the existing decode path.

Verification
REQ-032 Send 0xA5 codeword 0xA27 with out_ready = 1 -> data_out = 0xA5, err_corr = 0, err_uncorr = 0, out_valid two cycles after the last bit.
REQ-033 Send 0xA07 (index 5 flipped) -> data_out = 0xA5, err_corr = 1, corr_count = 1.
REQ-034 Send 0x226 (indices 0 and 11 flipped, s = 13) -> data_out = 0x25, err_uncorr = 1, uncorr_count = 1.
REQ-035 Hold out_ready = 0 and send two back-to-back words -> the first is held stable, the second is dropped, overrun = 1.
REQ-036 Send 6 bits, assert ser_sof, then send a full 0xA27 -> exactly one output, 0xA5.
REQ-037 Assert rst_n low while out_valid = 1 -> the next cycle has out_valid = 0 and all counters and flags at 0.
